// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared register map, CTRL bit positions and FSM encoding for the timer
package timer_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_LOAD   = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_IE      = 2;
    localparam int CTRL_PSC_LSB = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/timer_core.sv
// rtl/timer_core.sv - prescaler, down-counter and run/idle FSM of the timer
// A tick in RUN decrements COUNT; a tick at COUNT==0 is an expiry.
module timer_core import timer_pkg::*; #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_auto,
    input  logic [PRESCALE_W-1:0] i_psc,
    input  logic                  i_presc_clr,
    input  logic                  i_load_wr,
    input  logic [31:0]           i_load_wd,
    input  logic [31:0]           i_load,
    output logic [31:0]           o_count,
    output logic                  o_expire
);

    state_t                r_state;
    state_t                w_state_next;
    logic [PRESCALE_W-1:0] r_presc;
    logic [31:0]           r_count;
    logic                  w_tick;

    assign w_tick   = (r_state == ST_RUN) && i_en && (r_presc == i_psc);
    assign o_expire = w_tick && (r_count == 32'd0);
    assign o_count  = r_count;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_en) w_state_next = ST_RUN;
            ST_RUN:  if (!i_en || (o_expire && !i_auto)) w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (i_presc_clr || !i_en || (r_state != ST_RUN) || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // A LOAD write overrides both reload and decrement; COUNT never goes below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 32'd0;
        end else if (i_load_wr) begin
            r_count <= i_load_wd;
        end else if (w_tick) begin
            if (r_count != 32'd0) begin
                r_count <= r_count - 32'd1;
            end else if (i_auto) begin
                r_count <= i_load;
            end
        end
    end

endmodule

// File: rtl/timer_top.sv
// rtl/timer_top.sv - timer register file, read mux and interrupt around timer_core
// STATUS is write-one-to-clear; a coincident expiry wins over the clear.
module timer_top import timer_pkg::*; #(
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [1:0]  A,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        irq
);

    logic                  r_en;
    logic                  r_auto;
    logic                  r_ie;
    logic [PRESCALE_W-1:0] r_psc;
    logic [31:0]           r_load;
    logic                  r_exp;
    logic                  r_irq;

    logic                  w_ctrl_wr;
    logic                  w_load_wr;
    logic                  w_status_wr;
    logic                  w_presc_clr;
    logic                  w_expire;
    logic [31:0]           w_count;

    assign w_ctrl_wr   = WE && (A == ADDR_CTRL);
    assign w_load_wr   = WE && (A == ADDR_LOAD);
    assign w_status_wr = WE && (A == ADDR_STATUS);
    assign w_presc_clr = w_load_wr || (w_ctrl_wr && WD[CTRL_EN] && !r_en);

    timer_core #(.PRESCALE_W(PRESCALE_W)) u_core (
        .clk         (clk),
        .rst_n       (Rst),
        .i_en        (r_en),
        .i_auto      (r_auto),
        .i_psc       (r_psc),
        .i_presc_clr (w_presc_clr),
        .i_load_wr   (w_load_wr),
        .i_load_wd   (WD),
        .i_load      (r_load),
        .o_count     (w_count),
        .o_expire    (w_expire)
    );

    // A software CTRL write takes precedence over the one-shot self-disable.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_en   <= 1'b0;
            r_auto <= 1'b0;
            r_ie   <= 1'b0;
            r_psc  <= '0;
        end else if (w_ctrl_wr) begin
            r_en   <= WD[CTRL_EN];
            r_auto <= WD[CTRL_AUTO];
            r_ie   <= WD[CTRL_IE];
            r_psc  <= WD[CTRL_PSC_LSB +: PRESCALE_W];
        end else if (w_expire && !r_auto) begin
            r_en   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_load <= 32'd0;
            r_exp  <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            if (w_load_wr) begin
                r_load <= WD;
            end
            if (w_expire) begin
                r_exp <= 1'b1;
            end else if (w_status_wr && WD[0]) begin
                r_exp <= 1'b0;
            end
            r_irq <= r_exp & r_ie;
        end
    end

    assign irq = r_irq;

    always_comb begin
        RD = 32'd0;
        case (A)
            ADDR_CTRL: begin
                RD[CTRL_EN]                     = r_en;
                RD[CTRL_AUTO]                   = r_auto;
                RD[CTRL_IE]                     = r_ie;
                RD[CTRL_PSC_LSB +: PRESCALE_W]  = r_psc;
            end
            ADDR_LOAD:   RD = r_load;
            ADDR_COUNT:  RD = w_count;
            ADDR_STATUS: RD[0] = r_exp;
            default:     RD = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_top.sv
// tb/tb_timer_top.sv - self-checking bench for timer_top with a queue of expected results
module tb_timer_top;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        Rst = 1'b0;
    logic [1:0]  A   = 2'd0;
    logic        WE  = 1'b0;
    logic [31:0] WD  = 32'd0;
    logic [31:0] RD;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int sb[$];

    always #5 clk = ~clk;

    timer_top #(.PRESCALE_W(8)) dut (
        .clk (clk),
        .Rst (Rst),
        .A   (A),
        .WE  (WE),
        .WD  (WD),
        .RD  (RD),
        .irq (irq)
    );

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        A = a; WD = d; WE = 1'b1;
        @(negedge clk);
        WE = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        A = a;
        #1;
        d = RD;
    endtask

    task automatic do_reset;
        WE = 1'b0;
        Rst = 1'b0;
        repeat (2) @(negedge clk);
        Rst = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], v);
            total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_reg%0d got=%h exp=%h", a, v, 32'd0); end
        end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    endtask

    task automatic test_regs;
        logic [31:0] v;
        wr(ADDR_CTRL, 32'hFFFF_FF06);
        rd(ADDR_CTRL, v);
        total++; if (v !== 32'h0000_FF06) begin bad++; $display("FAIL ctrl_readback got=%h exp=%h", v, 32'h0000_FF06); end
        wr(ADDR_CTRL, 32'h0);
        wr(ADDR_LOAD, 32'hA5A5_0003);
        rd(ADDR_LOAD, v);
        total++; if (v !== 32'hA5A5_0003) begin bad++; $display("FAIL load_readback got=%h exp=%h", v, 32'hA5A5_0003); end
        rd(ADDR_COUNT, v);
        total++; if (v !== 32'hA5A5_0003) begin bad++; $display("FAIL load_sets_count got=%h exp=%h", v, 32'hA5A5_0003); end
        wr(ADDR_COUNT, 32'h55);
        rd(ADDR_COUNT, v);
        total++; if (v !== 32'hA5A5_0003) begin bad++; $display("FAIL count_ro got=%h exp=%h", v, 32'hA5A5_0003); end
    endtask

    task automatic test_oneshot;
        logic [31:0] c, s, last;
        int exp_v;
        bit done;
        done = 0;
        do_reset();
        wr(ADDR_LOAD, 32'd3);
        sb.push_back(3); sb.push_back(2); sb.push_back(1); sb.push_back(0);
        rd(ADDR_COUNT, last);
        exp_v = sb.pop_front();
        total++; if (last !== exp_v) begin bad++; $display("FAIL oneshot_count got=%h exp=%h", last, exp_v); end
        wr(ADDR_CTRL, 32'h1);
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            @(negedge clk);
            rd(ADDR_COUNT, c);
            if (c !== last) begin
                if (sb.size() == 0) begin
                    total++; bad++; $display("FAIL oneshot_extra_count got=%h exp=none", c);
                end else begin
                    exp_v = sb.pop_front();
                    total++; if (c !== exp_v) begin bad++; $display("FAIL oneshot_count got=%h exp=%h", c, exp_v); end
                end
                last = c;
            end
            rd(ADDR_STATUS, s);
            if (s[0]) done = 1;
        end
        total++; if (!done) begin bad++; $display("FAIL oneshot_timeout got=noexp exp=exp"); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL oneshot_early_exp got=%0d exp=0 pending", sb.size()); end
        sb.delete();
        rd(ADDR_CTRL, s);
        total++; if (s !== 32'h0) begin bad++; $display("FAIL oneshot_en_cleared got=%h exp=%h", s, 32'h0); end
        repeat (5) @(negedge clk);
        rd(ADDR_COUNT, c);
        total++; if (c !== 32'h0) begin bad++; $display("FAIL oneshot_nowrap got=%h exp=%h", c, 32'h0); end
    endtask

    task automatic test_auto;
        logic [31:0] c, s, prev;
        int nrel, lastcyc, exp_v;
        nrel = 0; lastcyc = 0; prev = '1;
        do_reset();
        wr(ADDR_LOAD, 32'd2);
        sb.push_back(15); sb.push_back(15);
        wr(ADDR_CTRL, 32'h0000_0403);
        for (int cyc = 0; cyc < 80 && nrel < 3; cyc++) begin
            @(negedge clk);
            WE = 1'b0;
            rd(ADDR_COUNT, c);
            rd(ADDR_STATUS, s);
            if (prev == 32'd0 && c == 32'd2) begin
                nrel++;
                if (nrel > 1) begin
                    exp_v = sb.pop_front();
                    total++; if (cyc - lastcyc != exp_v) begin bad++; $display("FAIL auto_period got=%0d exp=%0d", cyc - lastcyc, exp_v); end
                end
                total++; if (s[0] !== 1'b1) begin bad++; $display("FAIL auto_exp got=%b exp=1", s[0]); end
                lastcyc = cyc;
                A = ADDR_STATUS; WD = 32'h1; WE = 1'b1;
            end
            prev = c;
        end
        @(negedge clk);
        WE = 1'b0;
        total++; if (nrel < 3) begin bad++; $display("FAIL auto_timeout got=%0d exp=3 reloads", nrel); end
        sb.delete();
    endtask

    task automatic test_irq;
        logic [31:0] s;
        int exp_v;
        bit seen;
        seen = 0;
        do_reset();
        wr(ADDR_LOAD, 32'd0);
        wr(ADDR_CTRL, 32'h5);
        sb.push_back(0); sb.push_back(1);
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            rd(ADDR_STATUS, s);
            if (s[0]) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL irq_timeout got=noexp exp=exp"); end
        exp_v = sb.pop_front();
        total++; if (irq !== exp_v[0]) begin bad++; $display("FAIL irq_delay0 got=%b exp=%0d", irq, exp_v); end
        @(negedge clk);
        exp_v = sb.pop_front();
        total++; if (irq !== exp_v[0]) begin bad++; $display("FAIL irq_delay1 got=%b exp=%0d", irq, exp_v); end
        rd(ADDR_CTRL, s);
        total++; if (s !== 32'h4) begin bad++; $display("FAIL irq_ctrl got=%h exp=%h", s, 32'h4); end
        wr(ADDR_STATUS, 32'h0);
        rd(ADDR_STATUS, s);
        total++; if (s !== 32'h1) begin bad++; $display("FAIL w1c_zero got=%h exp=%h", s, 32'h1); end
        wr(ADDR_STATUS, 32'h1);
        rd(ADDR_STATUS, s);
        total++; if (s !== 32'h0) begin bad++; $display("FAIL w1c_clear got=%h exp=%h", s, 32'h0); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b exp=1", irq); end
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_drop got=%b exp=0", irq); end
    endtask

    task automatic test_clear_collision;
        logic [31:0] s;
        int t1, exp_v;
        bit seen, done;
        seen = 0; done = 0; t1 = 0;
        do_reset();
        wr(ADDR_LOAD, 32'd0);
        wr(ADDR_CTRL, 32'h0000_0703);
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            WE = 1'b0;
            rd(ADDR_STATUS, s);
            if (!seen && s[0]) begin
                seen = 1; t1 = cyc;
                sb.push_back(0); sb.push_back(1);
                WD = 32'h1; WE = 1'b1;
            end else if (seen && cyc == t1 + 1) begin
                exp_v = sb.pop_front();
                total++; if (s[0] !== exp_v[0]) begin bad++; $display("FAIL collide_preclear got=%b exp=%0d", s[0], exp_v); end
            end else if (seen && cyc == t1 + 7) begin
                WD = 32'h1; WE = 1'b1;
            end else if (seen && cyc == t1 + 8) begin
                exp_v = sb.pop_front();
                total++; if (s[0] !== exp_v[0]) begin bad++; $display("FAIL collide_set_wins got=%b exp=%0d", s[0], exp_v); end
                done = 1;
            end
        end
        @(negedge clk);
        WE = 1'b0;
        total++; if (!done) begin bad++; $display("FAIL collide_timeout got=notdone exp=done"); end
        sb.delete();
        wr(ADDR_CTRL, 32'h0);
    endtask

    task automatic test_load_collision;
        logic [31:0] c, s;
        int t, exp_v;
        bit seen, done;
        seen = 0; done = 0; t = 0;
        do_reset();
        wr(ADDR_LOAD, 32'd2);
        wr(ADDR_CTRL, 32'h0000_0303);
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            WE = 1'b0;
            rd(ADDR_COUNT, c);
            if (!seen && c == 32'd0) begin
                seen = 1; t = cyc;
            end
            if (seen && cyc == t + 3) begin
                rd(ADDR_STATUS, s);
                total++; if (s !== 32'h0) begin bad++; $display("FAIL ldcol_noexp_yet got=%h exp=%h", s, 32'h0); end
                sb.push_back(32'h10);
                A = ADDR_LOAD; WD = 32'h10; WE = 1'b1;
            end else if (seen && cyc == t + 4) begin
                exp_v = sb.pop_front();
                total++; if (c !== exp_v) begin bad++; $display("FAIL ldcol_count got=%h exp=%h", c, exp_v); end
                rd(ADDR_STATUS, s);
                total++; if (s !== 32'h1) begin bad++; $display("FAIL ldcol_exp got=%h exp=%h", s, 32'h1); end
                done = 1;
            end
        end
        total++; if (!done) begin bad++; $display("FAIL ldcol_timeout got=notdone exp=done"); end
        sb.delete();
        wr(ADDR_CTRL, 32'h0);
    endtask

    task automatic test_disable_resume;
        logic [31:0] c1, c2, c3;
        do_reset();
        wr(ADDR_LOAD, 32'd50);
        wr(ADDR_CTRL, 32'h1);
        repeat (5) @(negedge clk);
        wr(ADDR_CTRL, 32'h0);
        rd(ADDR_COUNT, c1);
        total++; if (c1 >= 32'd50 || c1 == 32'd0) begin bad++; $display("FAIL pause_range got=%0d exp=1..49", c1); end
        repeat (5) @(negedge clk);
        rd(ADDR_COUNT, c2);
        total++; if (c2 !== c1) begin bad++; $display("FAIL pause_hold got=%0d exp=%0d", c2, c1); end
        wr(ADDR_CTRL, 32'h1);
        repeat (5) @(negedge clk);
        rd(ADDR_COUNT, c3);
        total++; if (c3 >= c1) begin bad++; $display("FAIL resume got=%0d exp<%0d", c3, c1); end
        wr(ADDR_CTRL, 32'h0);
    endtask

    task automatic test_async_reset;
        logic [31:0] v;
        bit seen;
        seen = 0;
        do_reset();
        wr(ADDR_LOAD, 32'd6);
        wr(ADDR_CTRL, 32'h7);
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(negedge clk);
            if (irq) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL arst_irq_timeout got=0 exp=1"); end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 Rst = 1'b0;
        #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL arst_irq got=%b exp=0", irq); end
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], v);
            total++; if (v !== 32'd0) begin bad++; $display("FAIL arst_reg%0d got=%h exp=%h", a, v, 32'd0); end
        end
        @(negedge clk);
        A = ADDR_LOAD; WD = 32'h77; WE = 1'b1;
        repeat (2) @(negedge clk);
        WE = 1'b0;
        rd(ADDR_LOAD, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL arst_we_ignored got=%h exp=%h", v, 32'd0); end
        @(negedge clk);
        Rst = 1'b1;
        A = ADDR_LOAD; WD = 32'd9; WE = 1'b1;
        @(negedge clk);
        WE = 1'b0;
        rd(ADDR_LOAD, v);
        total++; if (v !== 32'd9) begin bad++; $display("FAIL arst_first_write got=%h exp=%h", v, 32'd9); end
        seen = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            rd(ADDR_STATUS, v);
            if (v[0] || irq) seen = 1;
        end
        total++; if (seen) begin bad++; $display("FAIL arst_no_late_exp got=1 exp=0"); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_oneshot();
        test_auto();
        test_irq();
        test_clear_collision();
        test_load_collision();
        test_disable_resume();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
